// File: rtl/myreg_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin arbiter in front of myreg_bb.
package myreg_arb_pkg;

  localparam int unsigned DEF_DATA_W = 64;
  localparam int unsigned MAX_REQ    = 8;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    WAIT,
    RESP
  } arb_state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/myreg_rr_arbiter_if.sv
// Requester-side and register-side signals of the arbiter, bundled for port use.
interface myreg_rr_arbiter_if
  import myreg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_wren;
  logic [NUM_REQ*DATA_W-1:0] req_wrdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]         resp_data;
  logic                      resp_err;
  logic                      reg_enable;
  logic                      reg_rqvalid;
  logic                      reg_wren;
  logic [DATA_W-1:0]         reg_wrdata;
  logic                      reg_rdvalid;
  logic [DATA_W-1:0]         reg_rddata;

  modport slave (
    input  req_valid, req_wren, req_wrdata, reg_rdvalid, reg_rddata,
    output req_ready, resp_valid, resp_data, resp_err,
           reg_enable, reg_rqvalid, reg_wren, reg_wrdata
  );

  modport master (
    output req_valid, req_wren, req_wrdata, reg_rdvalid, reg_rddata,
    input  req_ready, resp_valid, resp_data, resp_err,
           reg_enable, reg_rqvalid, reg_wren, reg_wrdata
  );

endinterface

// File: rtl/myreg_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick
  import myreg_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_onehot_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               any_o
);

  // cand[k] is the requester examined k-th, starting just after ptr.
  logic [IDX_W-1:0] cand [NUM_REQ];

  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand[k] = IDX_W'((32'(ptr_i) + k + 1) % NUM_REQ);
    end
  end

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_i[cand[k]]) begin
        any_o                  = 1'b1;
        gnt_idx_o              = cand[k];
        gnt_onehot_o[cand[k]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/myreg_rr_arbiter.sv
// Round-robin sequencer sharing one myreg_bb register among NUM_REQ requesters;
// one operation in flight, pulse issue, wait for rdvalid (or timeout), respond.
module myreg_rr_arbiter
  import myreg_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clock,
  input logic               reset,
  myreg_rr_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  gnt_q, gnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              en_q;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic [NUM_REQ-1:0] ready_c;
  logic [NUM_REQ-1:0] resp_valid_c;
  logic               rqvalid_c;
  logic               wren_c;
  logic [DATA_W-1:0]  wrdata_c;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i        (bus.req_valid),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (pick_onehot),
    .gnt_idx_o    (pick_idx),
    .any_o        (pick_any)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      timer_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      timer_q <= timer_d;
      data_q  <= data_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    timer_d      = timer_q;
    data_d       = data_q;
    err_d        = err_q;
    ready_c      = '0;
    resp_valid_c = '0;
    rqvalid_c    = 1'b0;
    wren_c       = 1'b0;
    wrdata_c     = '0;

    unique case (state_q)
      INIT: state_d = IDLE;

      IDLE: begin
        if (pick_any) begin
          ready_c   = pick_onehot;
          rqvalid_c = 1'b1;
          wren_c    = bus.req_wren[pick_idx];
          wrdata_c  = bus.req_wrdata[32'(pick_idx) * DATA_W +: DATA_W];
          gnt_d     = pick_idx;
          timer_d   = '0;
          state_d   = WAIT;
        end
      end

      WAIT: begin
        if (bus.reg_rdvalid) begin
          data_d  = bus.reg_rddata;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          timer_d = timer_q + TMR_W'(1);
          if (timer_d == TMR_W'(TIMEOUT)) begin
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      RESP: begin
        resp_valid_c[gnt_q] = 1'b1;
        ptr_d               = gnt_q;
        state_d             = IDLE;
      end

      default: state_d = INIT;
    endcase
  end

  // Combinational handshakes are masked while reset is high so an
  // in-flight or newly offered request never escapes during abort.
  always_comb begin
    bus.req_ready   = reset ? '0 : ready_c;
    bus.resp_valid  = reset ? '0 : resp_valid_c;
    bus.reg_rqvalid = rqvalid_c & ~reset;
    bus.reg_wren    = wren_c & ~reset;
    bus.reg_wrdata  = reset ? '0 : wrdata_c;
    bus.reg_enable  = ~reset & ((state_q == INIT) | en_q);
    bus.resp_data   = data_q;
    bus.resp_err    = err_q;
  end

endmodule

// File: tb/tb_myreg_rr_arbiter.sv
// Directed and randomized bench for myreg_rr_arbiter with a behavioural register model.
module tb_myreg_rr_arbiter;
  import myreg_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int TO = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  myreg_rr_arbiter_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  myreg_rr_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // myreg_bb stand-in: write on the issue edge, answer one cycle later
  logic [W-1:0] regmem = '0;
  logic [W-1:0] rd_q   = '0;
  logic         rv_q   = 1'b0;
  bit           mute   = 1'b0;
  bit           spur   = 1'b0;

  always @(posedge clock) begin
    rv_q <= bus.reg_rqvalid & ~mute;
    if (bus.reg_rqvalid) begin
      rd_q <= bus.reg_wren ? bus.reg_wrdata : regmem;
      if (bus.reg_wren) regmem <= bus.reg_wrdata;
    end
  end
  assign bus.reg_rdvalid = rv_q | spur;
  assign bus.reg_rddata  = rd_q;

  // requester stimulus
  logic [N-1:0] rq_v  = '0;
  logic [N-1:0] rq_wr = '0;
  logic [W-1:0] rq_data [N];
  bit hold      = 1'b0;
  bit auto_mode = 1'b0;

  // transaction-level reference model
  int unsigned cyc = 0;
  int unsigned busy_until = 0;
  int          ptr_m = N - 1;
  bit          pend = 1'b0;
  int          pend_idx = 0;
  logic [W-1:0] exp_data = '0;
  bit          exp_err = 1'b0;
  int unsigned resp_at = 0;
  logic [W-1:0] ref_mem = '0;
  logic [W-1:0] last_data = '0;
  int          acc_idx = -1;

  // observations of the DUT
  int          dut_grants [$];
  int unsigned dut_acc [$];
  int unsigned dut_resp_cnt = 0;
  int unsigned last_resp_cyc = 0;
  logic        obs_err = 1'b0;

  int n_pass = 0;
  int n_checks = 0;
  int n_fail = 0;
  int exp_order [5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i]          = rq_v[i];
      bus.req_wren[i]           = rq_wr[i];
      bus.req_wrdata[i*W +: W]  = rq_data[i];
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [W-1:0] d);
    rq_v[i]    = 1'b1;
    rq_wr[i]   = wr;
    rq_data[i] = d;
    drive();
  endtask

  task automatic check_cycle();
    logic [N-1:0] er;
    logic [N-1:0] ers;
    int g;
    int oi;
    er = '0; ers = '0; g = -1; oi = -1; acc_idx = -1;
    if (bus.resp_valid != '0) begin
      dut_resp_cnt++;
      last_resp_cyc = cyc;
      obs_err = bus.resp_err;
    end
    if (reset) begin
      chk("rst_ready", 64'(bus.req_ready), 0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 0);
      chk("rst_rqvalid", 64'(bus.reg_rqvalid), 0);
      chk("rst_enable", 64'(bus.reg_enable), 0);
      pend = 1'b0; busy_until = cyc + 1; ptr_m = N - 1; last_data = '0;
      return;
    end
    if ((bus.req_ready & bus.req_valid) != '0) begin
      for (int i = 0; i < N; i++)
        if (oi < 0 && bus.req_ready[i] && bus.req_valid[i]) oi = i;
      dut_grants.push_back(oi);
      dut_acc.push_back(cyc);
    end
    if (cyc > busy_until && rq_v != '0) begin
      for (int k = 1; k <= N; k++)
        if (g < 0 && rq_v[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      er[g] = 1'b1;
    end
    chk("ready", 64'(bus.req_ready), 64'(er));
    chk("ready_onehot0", 64'($onehot0(bus.req_ready)), 1);
    chk("enable", 64'(bus.reg_enable), 1);
    if (g >= 0) begin
      chk("issue_rqvalid", 64'(bus.reg_rqvalid), 1);
      chk("issue_wren", 64'(bus.reg_wren), 64'(rq_wr[g]));
      chk("issue_wrdata", bus.reg_wrdata, rq_data[g]);
      if (rq_wr[g]) ref_mem = rq_data[g];
      pend = 1'b1; pend_idx = g; exp_err = mute;
      exp_data = mute ? '0 : ref_mem;
      resp_at = mute ? cyc + 1 + TO : cyc + 2;
      busy_until = resp_at; ptr_m = g; acc_idx = g;
    end else begin
      chk("no_issue", 64'({bus.reg_rqvalid, bus.reg_wren}), 0);
    end
    if (pend && cyc == resp_at) begin
      ers[pend_idx] = 1'b1;
      chk("resp_valid", 64'(bus.resp_valid), 64'(ers));
      chk("resp_data", bus.resp_data, exp_data);
      chk("resp_err", 64'(bus.resp_err), 64'(exp_err));
      last_data = exp_data;
      pend = 1'b0;
    end else begin
      chk("resp_quiet", 64'(bus.resp_valid), 0);
      chk("resp_data_hold", bus.resp_data, last_data);
    end
  endtask

  task automatic update_reqs();
    if (acc_idx >= 0 && !hold) rq_v[acc_idx] = 1'b0;
    if (auto_mode) begin
      for (int i = 0; i < N; i++) begin
        if (!rq_v[i] && $urandom_range(0, 3) == 0) begin
          rq_v[i]    = 1'b1;
          rq_wr[i]   = 1'($urandom_range(0, 1));
          rq_data[i] = {$urandom, $urandom};
        end
      end
    end
    drive();
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    cyc++;
    update_reqs();
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k;
    k = 0;
    while ((pend || rq_v != '0) && k < budget) begin
      tick();
      k++;
    end
    if (pend || rq_v != '0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed still busy after %0d cycles, expected idle", tag, budget);
    end
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) tick();
    reset = 1'b0;
  endtask

  initial begin
    int base;
    int unsigned rc;
    for (int i = 0; i < N; i++) rq_data[i] = '0;
    drive();
    @(posedge clock);
    #1;
    cyc = 1;

    // 1: first write after reset goes to requester 0
    do_reset(3);
    base = dut_grants.size();
    set_req(0, 1'b1, 64'hDEAD_BEEF_0000_0001);
    wait_done(20, "t1_wait");
    if (dut_grants.size() > base) begin
      chk("t1_grant", 64'(dut_grants[base]), 0);
      chk("t1_latency", 64'(last_resp_cyc - dut_acc[base]), 2);
    end else chk("t1_grant_seen", 64'(dut_grants.size()), 64'(base + 1));
    chk("t1_resp_data", bus.resp_data, 64'hDEAD_BEEF_0000_0001);

    // 2: all four held reads rotate 0,1,2,3,0 at one per 3 cycles
    do_reset(2);
    base = dut_grants.size();
    hold = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, '0);
    for (int k = 0; k < 40 && dut_grants.size() < base + 5; k++) tick();
    hold = 1'b0;
    if (dut_grants.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) chk("t2_order", 64'(dut_grants[base+k]), 64'(exp_order[k]));
      for (int k = 0; k < 4; k++) chk("t2_gap", 64'(dut_acc[base+k+1] - dut_acc[base+k]), 3);
    end else chk("t2_grant_count", 64'(dut_grants.size() - base), 5);
    wait_done(60, "t2_drain");

    // 3: write from requester 2 is visible to requester 1
    set_req(2, 1'b1, 64'h55);
    wait_done(20, "t3_write");
    set_req(1, 1'b0, '0);
    wait_done(20, "t3_read");
    chk("t3_read_data", bus.resp_data, 64'h55);
    chk("t3_read_err", 64'(obs_err), 0);

    // 4: silent register produces a timeout error, then service resumes
    mute = 1'b1;
    set_req(3, 1'b0, '0);
    wait_done(TO + 10, "t4_timeout");
    chk("t4_err_data", bus.resp_data, 0);
    chk("t4_err_flag", 64'(obs_err), 1);
    mute = 1'b0;
    set_req(0, 1'b0, '0);
    wait_done(20, "t4_recover");
    chk("t4_next_data", bus.resp_data, 64'h55);
    chk("t4_next_err", 64'(obs_err), 0);

    // 5: reset while waiting aborts the op; requester 0 wins first afterwards
    set_req(1, 1'b1, 64'h1234);
    for (int k = 0; k < 10 && !pend; k++) tick();
    tick();
    rc = dut_resp_cnt;
    do_reset(2);
    chk("t5_no_resp", 64'(dut_resp_cnt), 64'(rc));
    rq_v = '0;
    base = dut_grants.size();
    set_req(2, 1'b0, '0);
    set_req(0, 1'b0, '0);
    wait_done(30, "t5_after");
    if (dut_grants.size() >= base + 2) begin
      chk("t5_first_grant", 64'(dut_grants[base]), 0);
      chk("t5_second_grant", 64'(dut_grants[base+1]), 2);
    end else chk("t5_grant_count", 64'(dut_grants.size() - base), 2);
    chk("t5_data", bus.resp_data, 64'h1234);

    // 6: spurious rdvalid while idle is ignored
    tick();
    rc = dut_resp_cnt;
    spur = 1'b1;
    repeat (3) tick();
    spur = 1'b0;
    chk("t6_no_resp", 64'(dut_resp_cnt), 64'(rc));
    base = dut_grants.size();
    set_req(3, 1'b0, '0);
    tick();
    chk("t6_immediate_grant", 64'(dut_grants.size()), 64'(base + 1));
    wait_done(20, "t6_drain");

    // random traffic against the model
    auto_mode = 1'b1;
    repeat (400) tick();
    auto_mode = 1'b0;
    wait_done(200, "rand_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
